// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staggered multi-channel reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        StPor,
        StRelease,
        StHold,
        StRun
    } seq_state_e;

    localparam int unsigned NUM_CH_MAX = 16;

    // Counter value (relative to RELEASE entry) at which channel k is unmasked.
    function automatic int unsigned release_cycle(input int unsigned k,
                                                  input int unsigned stagger);
        return k * stagger;
    endfunction

endpackage

// File: rtl/reset_sequencer_stretch.sv
// Per-channel software reset stretcher: holds active_o while req_i is high and for at least
// MIN_CYCLES cycles after each rising edge of req_i.
module rst_pulse_stretch #(
    parameter int unsigned MIN_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    output logic active_o
);

    localparam int unsigned CW = $clog2(MIN_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'((MIN_CYCLES == 32'd0) ? 32'd0 : MIN_CYCLES - 32'd1);

    logic          req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          rise;

    always_comb begin
        rise     = req_i & ~req_q;
        req_d    = req_i;
        cnt_d    = cnt_q;
        if (rise) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        // The cycle of assertion counts as the first of the minimum window.
        active_d = req_i | (cnt_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: power-on hold, staggered release, software reset stretching.
// Optional macro RSTSEQ_SYNC_EN adds two-flop synchronisers on the software reset requests.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned POR_CYCLES     = 32'h800000,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned SW_PULSE_MIN   = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw_reset_i,
    input  logic              sw_reset_all_i,
    output logic [NUM_CH-1:0] local_reset_o,
    output logic              initial_reset_o,
    output logic              seq_done_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] POR_LAST =
        CNT_W'((POR_CYCLES == 32'd0) ? 32'd0 : POR_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((SW_PULSE_MIN == 32'd0) ? 32'd0 : SW_PULSE_MIN - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] sw_req;
    logic              all_req;

`ifdef RSTSEQ_SYNC_EN
    logic [NUM_CH:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = {sw_reset_all_i, sw_reset_i};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign {all_req, sw_req} = sync2_q;
`else
    assign sw_req  = sw_reset_i;
    assign all_req = sw_reset_all_i;
`endif

    logic [NUM_CH-1:0] stretch_active;
    logic [NUM_CH-1:0] rel_hit;
    logic [CNT_W-1:0]  cnt_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [CNT_W-1:0] REL_AT = CNT_W'(release_cycle(k, STAGGER_CYCLES));

        assign rel_hit[k] = (cnt_q == REL_AT);

        rst_pulse_stretch #(
            .MIN_CYCLES(SW_PULSE_MIN)
        ) u_stretch (
            .clk     (clk),
            .rst     (rst),
            .req_i   (sw_req[k]),
            .active_o(stretch_active[k])
        );
    end

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_d, cnt_inc;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              initial_reset_q, seq_done_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        unique case (state_q)
            StPor: begin
                if (cnt_q == POR_LAST) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRelease: begin
                // A global request wins over any release due in the same cycle.
                if (all_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_q | rel_hit;
                    cnt_d  = cnt_inc;
                    if (rel_hit[NUM_CH-1]) begin
                        state_d = StRun;
                    end
                end
            end
            StHold: begin
                if (cnt_q == HOLD_LAST) begin
                    if (!all_req) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRun: begin
                if (all_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = StPor;
                cnt_d   = '0;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StPor;
            cnt_q           <= '0;
            mask_q          <= '0;
            initial_reset_q <= 1'b1;
            seq_done_q      <= 1'b0;
            busy_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mask_q          <= mask_d;
            initial_reset_q <= (state_d == StPor);
            seq_done_q      <= (state_d == StRun);
            busy_q          <= (state_d != StRun);
        end
    end

    assign local_reset_o   = ~mask_q | stretch_active;
    assign initial_reset_o = initial_reset_q;
    assign seq_done_o      = seq_done_q;
    assign busy_o          = busy_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised multi-channel successor to the single-domain local reset generator.
- Holds all channels in reset for a power-on interval, then releases them one at a time with a fixed stagger.
- Afterwards, per-channel software resets stretch to a minimum pulse width; a global software reset re-runs the stagger sequence.
- Sits at the top level, fanning resets out to the DSP, USB/FIFO and register-file domains.

Parameters:
NUM_CH, 4, number of reset channels (1..16)
POR_CYCLES, 32'h800000, power-on hold length in clk cycles (0 treated as 1)
STAGGER_CYCLES, 16, cycles between successive channel releases (0 = release all together)
SW_PULSE_MIN, 16, minimum width of a software-requested reset in cycles (>=1)
CNT_W, 32, width of the internal sequencing counter; must hold POR_CYCLES and NUM_CH*STAGGER_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset; one clock domain, all state cleared on assertion
sw_reset_i  in  NUM_CH  per-channel software reset request, level
sw_reset_all_i  in  1  global software reset request, level
local_reset_o  out  NUM_CH  per-channel reset, active-high, registered
initial_reset_o  out  1  high during the power-on interval only, registered
seq_done_o  out  1  high once all channels are released by the sequencer
busy_o  out  1  high in POR, HOLD or RELEASE

Behaviour:
- Reset values while rst=1:
  - state=POR, cnt=0
  - local_reset_o all 1, initial_reset_o=1, seq_done_o=0, busy_o=1
  - all stretchers idle
- POR state:
  - cnt increments each cycle; on cnt==POR_CYCLES-1 go to RELEASE with cnt=0.
  - initial_reset_o is 1 for exactly POR_CYCLES cycles after rst deasserts, then falls on the first RELEASE cycle (T).
  - initial_reset_o never reasserts without rst.
  - sw_reset_all_i is ignored in POR.
- RELEASE state:
  - Release mask bit k sets when cnt==k*STAGGER_CYCLES.
  - local_reset_o[k] falls at T+1+k*STAGGER_CYCLES, unless its stretcher is active.
  - After bit NUM_CH-1 sets, go to RUN; seq_done_o rises on the same edge local_reset_o[NUM_CH-1] falls.
- RUN state:
  - local_reset_o[k] = ~mask[k] | stretch_active[k].
  - seq_done_o=1, busy_o=0.
- Per-channel stretcher (active in all states):
  - Rising sw_reset_i[k] asserts stretch_active[k] on the next edge.
  - stretch_active[k] stays high while sw_reset_i[k] is high, and for at least SW_PULSE_MIN cycles from assertion.
  - A new rising edge inside the window restarts the minimum count.
  - A request during POR/RELEASE is OR'ed with the sequencer mask; the channel deasserts only when both allow it.
- HOLD state (global software reset):
  - sw_reset_all_i=1 sampled in RELEASE or RUN → next edge: mask cleared (all local_reset_o=1), seq_done_o=0, state=HOLD, cnt=0.
  - HOLD lasts max(SW_PULSE_MIN cycles, while sw_reset_all_i high); then go to RELEASE with cnt=0 and repeat the stagger.
  - sw_reset_all_i asserted during RELEASE aborts the sequence into HOLD.
- Simultaneous events:
  - sw_reset_all_i wins over mask updates in the same cycle.
  - rst overrides everything asynchronously.
  - rst asserted mid-sequence returns to POR with the full interval.
- Counter:
  - Unsigned CNT_W bits; saturates, never wraps.
  - Compare with == against parameter-derived constants, computed at elaboration.

Optional Feature:
- Macro: RSTSEQ_SYNC_EN.
- Defined: sw_reset_i and sw_reset_all_i each pass through a two-flop synchroniser, reset to 0. This adds 2 cycles of request-to-assert latency (3 cycles total to local_reset_o). Edge detection uses the synchronised value.
- Undefined: inputs are treated as synchronous to clk; latency is 1 cycle.

Decomposition:
- Package reset_sequencer_pkg:
  - state enum {POR, RELEASE, HOLD, RUN}, 2 bits
  - NUM_CH_MAX=16
  - function returning the release cycle for channel k
- Sub-module rst_pulse_stretch: one instance per channel.
  - Ports: clk, rst, req_i, active_o; parameter MIN_CYCLES.
  - Internal counter of width $clog2(MIN_CYCLES+1).

Test Plan (NUM_CH=4, POR_CYCLES=100, STAGGER_CYCLES=4, SW_PULSE_MIN=8, sync off):
- Release rst at cycle 0 → initial_reset_o high cycles 0-99, falls at 100; local_reset_o[0..3] fall at 101,105,109,113; seq_done_o rises at 113.
- In RUN, pulse sw_reset_i[2] for 1 cycle at cycle 200 → local_reset_o[2] high 201-208 exactly; other channels stay 0.
- In RUN, hold sw_reset_i[1] high 200-229 → local_reset_o[1] high 201-230; repulse at 205 while stretching → window restarts, no glitch.
- In RUN, pulse sw_reset_all_i at 300 → all channels high at 301, seq_done_o=0; HOLD 8 cycles; channels fall at 310,314,318,322; initial_reset_o stays 0.
- Assert rst at cycle 107 (mid-RELEASE) → all outputs return to reset values immediately; full 100-cycle POR repeats after release.
- With RSTSEQ_SYNC_EN, pulse sw_reset_i[0] at 200 → local_reset_o[0] rises at 203, width 8.
